tt_um_adder_seq: RTL and testbench

Parametrised, multi-cycle successor to the 4-bit combinational adder tile. It accepts two WIDTH-bit operands as a stream of nibble pairs on the dedicated inputs and adds or subtracts them one nibble per cycle through a registered carry. It returns the result a byte at a time under a ready/valid handshake, together with carry and signed-overflow flags. It sits at the Tiny Tapeout user-project top level and uses the standard tile pinout.

---
 rtl/adder_seq_pkg.sv | 21 ++
 rtl/adder_nibble.sv | 24 ++
 rtl/tt_um_adder_seq.sv | 157 +++++++++++++++
 tb/tb_tt_um_adder_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and pin-index constants for the sequential nibble adder tile.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        LOAD,
        CALC,
        OUT
    } state_t;

    localparam int unsigned IN_VALID  = 0;
    localparam int unsigned SUB       = 1;
    localparam int unsigned OUT_READY = 2;
    localparam int unsigned CLEAR     = 3;
    localparam int unsigned BUSY      = 4;
    localparam int unsigned OUT_VALID = 5;
    localparam int unsigned CARRY     = 6;
    localparam int unsigned OVF       = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/adder_nibble.sv
// 4-bit combinational adder slice; msb_ci exposes the carry into bit 3 for
// signed-overflow detection.
module adder_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       msb_ci
);

    logic [3:0] low_sum;
    logic [4:0] full_sum;

    always_comb begin
        low_sum  = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
        full_sum = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    end

    assign s      = full_sum[3:0];
    assign co     = full_sum[4];
    assign msb_ci = low_sum[3];

endmodule

// File: rtl/tt_um_adder_seq.sv
// Multi-cycle add/subtract tile: nibble-serial operand load, nibble-serial
// ripple through one shared adder slice, byte-serial result under ready/valid.
module tt_um_adder_seq
    import adder_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned NBYTE = WIDTH / 8;
    localparam int unsigned CW    = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned BW    = (NBYTE > 1) ? $clog2(NBYTE) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(NIB - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTE - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    byte_idx;
    logic [BW-1:0]    byte_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             sub_q;
    logic             c_q;
    logic             out_valid_q;
    logic             carry_q;
    logic             ovf_q;
    logic [7:0]       uo_q;

    logic       in_valid;
    logic       sub;
    logic       out_ready;
    logic       clear;
    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [3:0] s_nib;
    logic       co;
    logic       msb_ci;
    logic       unused_ok;

    assign in_valid  = uio_in[IN_VALID];
    assign sub       = uio_in[SUB];
    assign out_ready = uio_in[OUT_READY];
    assign clear     = uio_in[CLEAR];
    assign unused_ok = &{1'b0, ena, uio_in[7:4]};

    assign byte_next = byte_idx + 1'b1;
    assign a_nib     = a_q[{cnt, 2'b00} +: 4];
    assign b_nib     = sub_q ? ~b_q[{cnt, 2'b00} +: 4] : b_q[{cnt, 2'b00} +: 4];

    adder_nibble u_adder (
        .a      (a_nib),
        .b      (b_nib),
        .ci     (c_q),
        .s      (s_nib),
        .co     (co),
        .msb_ci (msb_ci)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            cnt         <= '0;
            byte_idx    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            sub_q       <= 1'b0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            uo_q        <= '0;
        end else if (clear) begin
            state       <= LOAD;
            cnt         <= '0;
            byte_idx    <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            uo_q        <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        a_q[{cnt, 2'b00} +: 4] <= ui_in[3:0];
                        b_q[{cnt, 2'b00} +: 4] <= ui_in[7:4];
                        if (cnt == '0) begin
                            sub_q <= sub;
                        end
                        if (cnt == CNT_LAST) begin
                            state <= CALC;
                            cnt   <= '0;
                            c_q   <= sub_q;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CALC: begin
                    s_q[{cnt, 2'b00} +: 4] <= s_nib;
                    c_q <= co;
                    if (cnt == CNT_LAST) begin
                        carry_q  <= co;
                        ovf_q    <= co ^ msb_ci;
                        state    <= OUT;
                        cnt      <= '0;
                        byte_idx <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    // First OUT cycle presents byte 0 from the now-complete s_q.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        uo_q        <= s_q[7:0];
                    end else if (out_ready) begin
                        if (byte_idx == BYTE_LAST) begin
                            state       <= LOAD;
                            byte_idx    <= '0;
                            out_valid_q <= 1'b0;
                            carry_q     <= 1'b0;
                            ovf_q       <= 1'b0;
                            uo_q        <= '0;
                        end else begin
                            byte_idx <= byte_next;
                            uo_q     <= s_q[{byte_next, 3'b000} +: 8];
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    always_comb begin
        uio_out            = '0;
        uio_out[BUSY]      = (state != LOAD);
        uio_out[OUT_VALID] = out_valid_q;
        uio_out[CARRY]     = carry_q;
        uio_out[OVF]       = ovf_q;
    end

    assign uo_out = uo_q;
    assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_adder_seq.sv
// Randomised self-checking bench for tt_um_adder_seq at WIDTH 8, 16 and 32.
module tb_tt_um_adder_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_v   [3];
    logic [7:0] uio_v  [3];
    logic [7:0] uo_v   [3];
    logic [7:0] uioo_v [3];
    logic [7:0] oe_v   [3];

    int tests;
    int fails;

    tt_um_adder_seq #(.WIDTH(8)) dut8 (
        .ui_in(ui_v[0]), .uo_out(uo_v[0]), .uio_in(uio_v[0]), .uio_out(uioo_v[0]),
        .uio_oe(oe_v[0]), .ena(1'b1), .clk(clk), .rst_n(rst_n)
    );
    tt_um_adder_seq #(.WIDTH(16)) dut16 (
        .ui_in(ui_v[1]), .uo_out(uo_v[1]), .uio_in(uio_v[1]), .uio_out(uioo_v[1]),
        .uio_oe(oe_v[1]), .ena(1'b1), .clk(clk), .rst_n(rst_n)
    );
    tt_um_adder_seq #(.WIDTH(32)) dut32 (
        .ui_in(ui_v[2]), .uo_out(uo_v[2]), .uio_in(uio_v[2]), .uio_out(uioo_v[2]),
        .uio_oe(oe_v[2]), .ena(1'b1), .clk(clk), .rst_n(rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int wid(input int sel);
        return 8 << sel;
    endfunction

    // Reference: plain modular arithmetic with sign-based overflow rules.
    function automatic void model(input int w, input longint unsigned a_in, input longint unsigned b_in,
                                  input bit sub, output longint unsigned r, output bit c, output bit v);
        longint unsigned mask;
        longint unsigned a;
        longint unsigned b;
        bit sa, sb, sr;
        mask = (64'd1 << w) - 64'd1;
        a = a_in & mask;
        b = b_in & mask;
        if (sub) begin
            r = (a - b) & mask;
            c = (a >= b);
        end else begin
            r = (a + b) & mask;
            c = ((a + b) > mask);
        end
        sa = 1'((a >> (w - 1)) & 64'd1);
        sb = 1'((b >> (w - 1)) & 64'd1);
        sr = 1'((r >> (w - 1)) & 64'd1);
        if (sub) v = (sa != sb) && (sr != sa);
        else     v = (sa == sb) && (sr != sa);
    endfunction

    task automatic load_beats(input int sel, input longint unsigned a, input longint unsigned b,
                              input bit sub, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                repeat ($urandom_range(1, 2)) begin
                    ui_v[sel]  = 8'($urandom);
                    uio_v[sel] = {4'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b0};
                    @(posedge clk); #1;
                end
            end
            ui_v[sel]  = {4'(b >> (4 * i)), 4'(a >> (4 * i))};
            uio_v[sel] = {4'($urandom), 1'b0, 1'($urandom), (i == 0) ? sub : 1'($urandom), 1'b1};
            @(posedge clk); #1;
        end
    endtask

    task automatic run_out(input int sel, input longint unsigned a, input longint unsigned b,
                           input bit sub, input int bp0, input bit rbp);
        longint unsigned r;
        bit c, v;
        int nib, nbyte, nbp;
        logic [7:0] exp_b, exp_u;
        nib   = wid(sel) / 4;
        nbyte = wid(sel) / 8;
        model(wid(sel), a, b, sub, r, c, v);

        tests++;
        if (uioo_v[sel][4] !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_load w=%0d: got %b expected 1", wid(sel), uioo_v[sel][4]);
        end
        for (int k = 1; k <= nib; k++) begin
            ui_v[sel]  = 8'($urandom);
            uio_v[sel] = {4'($urandom), 1'b0, 1'b0, 1'($urandom), 1'b1};
            @(posedge clk); #1;
            tests++;
            if (uioo_v[sel][5] !== 1'b0) begin
                fails++;
                $display("FAIL calc_no_valid w=%0d cyc=%0d: got %b expected 0", wid(sel), k, uioo_v[sel][5]);
            end
        end
        @(posedge clk); #1;

        for (int j = 0; j < nbyte; j++) begin
            exp_b = 8'(r >> (8 * j));
            exp_u = {v, c, 1'b1, 1'b1, 4'b0000};
            nbp   = (j == 0) ? bp0 : (rbp ? int'($urandom_range(0, 2)) : 0);
            uio_v[sel] = {4'($urandom), 1'b0, 1'b0, 1'($urandom), 1'b1};
            for (int q = 0; q < nbp; q++) begin
                @(posedge clk); #1;
                tests++;
                if (uo_v[sel] !== exp_b || uioo_v[sel] !== exp_u) begin
                    fails++;
                    $display("FAIL backpressure w=%0d byte=%0d: got uo=%h uio=%h expected uo=%h uio=%h",
                             wid(sel), j, uo_v[sel], uioo_v[sel], exp_b, exp_u);
                end
            end
            tests++;
            if (uo_v[sel] !== exp_b) begin
                fails++;
                $display("FAIL out_byte w=%0d byte=%0d a=%h b=%h sub=%b: got %h expected %h",
                         wid(sel), j, a, b, sub, uo_v[sel], exp_b);
            end
            tests++;
            if (uioo_v[sel] !== exp_u) begin
                fails++;
                $display("FAIL out_flags w=%0d byte=%0d a=%h b=%h sub=%b: got %h expected %h",
                         wid(sel), j, a, b, sub, uioo_v[sel], exp_u);
            end
            uio_v[sel] = {4'($urandom), 1'b0, 1'b1, 1'($urandom), 1'b1};
            @(posedge clk); #1;
        end
        uio_v[sel] = 8'h00;
        tests++;
        if (uo_v[sel] !== 8'h00 || uioo_v[sel] !== 8'h00) begin
            fails++;
            $display("FAIL return_to_load w=%0d: got uo=%h uio=%h expected 00 00", wid(sel), uo_v[sel], uioo_v[sel]);
        end
    endtask

    task automatic do_op(input int sel, input longint unsigned a, input longint unsigned b,
                         input bit sub, input bit gaps, input int bp0, input bit rbp);
        load_beats(sel, a, b, sub, wid(sel) / 4, gaps);
        run_out(sel, a, b, sub, bp0, rbp);
    endtask

    task automatic check_idle_outputs(input string name);
        for (int s = 0; s < 3; s++) begin
            tests++;
            if (uo_v[s] !== 8'h00 || uioo_v[s] !== 8'h00 || oe_v[s] !== 8'hF0) begin
                fails++;
                $display("FAIL %s w=%0d: got uo=%h uio=%h oe=%h expected 00 00 f0",
                         name, wid(s), uo_v[s], uioo_v[s], oe_v[s]);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            ui_v[s]  = 8'h00;
            uio_v[s] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        do_op(1, 64'h1234, 64'h0FFF, 1'b0, 1'b0, 5, 1'b0);
        do_op(1, 64'hFFFF, 64'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_op(1, 64'h7FFF, 64'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_op(1, 64'h0005, 64'h0007, 1'b1, 1'b0, 0, 1'b0);
        do_op(1, 64'h1234, 64'h0FFF, 1'b0, 1'b1, 2, 1'b1);
        do_op(0, 64'h34, 64'hFF, 1'b0, 1'b0, 0, 1'b0);
        do_op(0, 64'h7F, 64'h01, 1'b0, 1'b0, 0, 1'b0);
        do_op(2, 64'h12345678, 64'h0FFF0FFF, 1'b0, 1'b0, 0, 1'b0);
        do_op(2, 64'h80000000, 64'h00000001, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) begin
            do_op(1, 64'($urandom), 64'($urandom), 1'($urandom), 1'b0, 0, 1'b0);
        end
    endtask

    task automatic test_clear_load;
        load_beats(1, 64'hABCD, 64'h5555, 1'b1, 2, 1'b0);
        ui_v[1]  = 8'($urandom);
        uio_v[1] = 8'h0F;
        @(posedge clk); #1;
        uio_v[1] = 8'h00;
        tests++;
        if (uioo_v[1] !== 8'h00) begin
            fails++;
            $display("FAIL clear_in_load: got uio=%h expected 00", uioo_v[1]);
        end
        do_op(1, 64'h1234, 64'h0FFF, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_clear_out;
        load_beats(2, 64'hDEADBEEF, 64'h01010101, 1'b0, 8, 1'b0);
        uio_v[2] = 8'h00;
        repeat (9) @(posedge clk);
        #1;
        tests++;
        if (uioo_v[2][5] !== 1'b1 || uo_v[2] !== 8'hF0) begin
            fails++;
            $display("FAIL clear_setup: got uo=%h valid=%b expected f0 1", uo_v[2], uioo_v[2][5]);
        end
        uio_v[2] = 8'h0C;
        @(posedge clk); #1;
        uio_v[2] = 8'h00;
        tests++;
        if (uo_v[2] !== 8'h00 || uioo_v[2] !== 8'h00) begin
            fails++;
            $display("FAIL clear_in_out: got uo=%h uio=%h expected 00 00", uo_v[2], uioo_v[2]);
        end
        do_op(2, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid(input int wait_cycles, input string name);
        load_beats(1, 64'h1234, 64'h0FFF, 1'b0, 4, 1'b0);
        uio_v[1] = 8'h00;
        repeat (wait_cycles) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs(name);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(1, 64'($urandom), 64'($urandom), 1'($urandom), 1'b0, 0, 1'b0);
    endtask

    task automatic test_random;
        int sel;
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 2));
            do_op(sel, {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
                  1'($urandom), 1'b1, int'($urandom_range(0, 3)), 1'b1);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_clear_load();
        test_clear_out();
        test_reset_mid(2, "reset_mid_calc");
        test_reset_mid(6, "reset_mid_out");
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
